// File: rtl/surf_event_sequencer_if.sv
// Stream bundle between the SURF byte sources and the merged event output.
// The master modport is the sequencer's view; slave is the environment's.
interface surf_event_sequencer_if #(
    parameter int NUM_SURF = 7
);
    logic [8*NUM_SURF-1:0] s_dout_tdata;
    logic [NUM_SURF-1:0]   s_dout_tvalid;
    logic [NUM_SURF-1:0]   s_dout_tlast;
    logic [NUM_SURF-1:0]   s_dout_tready;
    logic [7:0]            m_dout_tdata;
    logic                  m_dout_tvalid;
    logic                  m_dout_tlast;
    logic                  m_dout_tready;

    modport master (
        input  s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_dout_tready,
        output s_dout_tready, m_dout_tdata, m_dout_tvalid, m_dout_tlast
    );

    modport slave (
        output s_dout_tdata, s_dout_tvalid, s_dout_tlast, m_dout_tready,
        input  s_dout_tready, m_dout_tdata, m_dout_tvalid, m_dout_tlast
    );
endinterface

// File: rtl/surf_event_sequencer.sv
// Merges per-SURF byte streams into one event: enabled SURFs are read out in
// ascending order, a stalled SURF is skipped after timeout_i idle cycles.
module surf_event_sequencer #(
    parameter int NUM_SURF      = 7,
    parameter int TIMEOUT_WIDTH = 24
) (
    input  logic                     aclk,
    input  logic                     aresetn,
    input  logic [NUM_SURF-1:0]      enable_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    surf_event_sequencer_if.master   bus,
    output logic [2:0]               cur_surf_o,
    output logic [15:0]              event_count_o,
    output logic                     timeout_err_o
);

    typedef enum logic [1:0] {IDLE, STREAM, NEXT, TERM} state_t;

    state_t                   state, state_nx;
    logic [2:0]               sel, sel_nx;
    logic [NUM_SURF-1:0]      en_q, en_q_nx;
    logic [TIMEOUT_WIDTH-1:0] stall_cnt, stall_nx;
    logic [15:0]              event_cnt_nx;
    logic                     err_nx;

    logic       sel_tvalid, sel_tlast;
    logic [7:0] sel_tdata;
    logic       first_found, first_tvalid;
    logic [2:0] first_idx;
    logic [2:0] last_idx;
    logic       next_found;
    logic [2:0] next_idx;
    logic       is_last;
    logic       beat;

    // Source mux plus priority searches over enable_i (event start) and en_q.
    always_comb begin
        sel_tvalid   = 1'b0;
        sel_tlast    = 1'b0;
        sel_tdata    = '0;
        first_found  = 1'b0;
        first_tvalid = 1'b0;
        first_idx    = '0;
        last_idx     = '0;
        next_found   = 1'b0;
        next_idx     = '0;
        for (int i = 0; i < NUM_SURF; i++) begin
            if (3'(i) == sel) begin
                sel_tvalid = bus.s_dout_tvalid[i];
                sel_tlast  = bus.s_dout_tlast[i];
                sel_tdata  = bus.s_dout_tdata[8*i +: 8];
            end
            if (en_q[i]) last_idx = 3'(i);
        end
        for (int i = NUM_SURF - 1; i >= 0; i--) begin
            if (enable_i[i]) begin
                first_found  = 1'b1;
                first_idx    = 3'(i);
                first_tvalid = bus.s_dout_tvalid[i];
            end
            if (en_q[i] && (3'(i) > sel)) begin
                next_found = 1'b1;
                next_idx   = 3'(i);
            end
        end
    end

    assign is_last = (sel == last_idx);
    assign beat    = (state == STREAM) && sel_tvalid && bus.m_dout_tready;

    always_comb begin
        state_nx          = state;
        sel_nx            = sel;
        en_q_nx           = en_q;
        stall_nx          = stall_cnt;
        event_cnt_nx      = event_count_o;
        err_nx            = timeout_err_o;
        bus.m_dout_tvalid = 1'b0;
        bus.m_dout_tdata  = '0;
        bus.m_dout_tlast  = 1'b0;
        bus.s_dout_tready = '0;

        unique case (state)
            IDLE: begin
                if (first_found && first_tvalid) begin
                    en_q_nx  = enable_i;
                    sel_nx   = first_idx;
                    stall_nx = '0;
                    state_nx = STREAM;
                end
            end

            STREAM: begin
                bus.m_dout_tvalid = sel_tvalid;
                bus.m_dout_tdata  = sel_tdata;
                bus.m_dout_tlast  = sel_tvalid && sel_tlast && is_last;
                for (int i = 0; i < NUM_SURF; i++) begin
                    if (3'(i) == sel) bus.s_dout_tready[i] = bus.m_dout_tready;
                end
                if (beat) begin
                    stall_nx = '0;
                    if (sel_tlast) state_nx = NEXT;
                end else if (bus.m_dout_tready && (timeout_i != '0)) begin
                    // Only idle cycles with downstream ready count as a stall.
                    if ((stall_cnt + TIMEOUT_WIDTH'(1)) >= timeout_i) begin
                        err_nx   = 1'b1;
                        stall_nx = '0;
                        state_nx = is_last ? TERM : NEXT;
                    end else begin
                        stall_nx = stall_cnt + TIMEOUT_WIDTH'(1);
                    end
                end
            end

            NEXT: begin
                if (next_found) begin
                    sel_nx   = next_idx;
                    stall_nx = '0;
                    state_nx = STREAM;
                end else begin
                    event_cnt_nx = event_count_o + 16'd1;
                    state_nx     = IDLE;
                end
            end

            TERM: begin
                // Closes an event whose last SURF never delivered its tlast.
                bus.m_dout_tvalid = 1'b1;
                bus.m_dout_tdata  = 8'h00;
                bus.m_dout_tlast  = 1'b1;
                if (bus.m_dout_tready) begin
                    event_cnt_nx = event_count_o + 16'd1;
                    state_nx     = IDLE;
                end
            end

            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state         <= IDLE;
            sel           <= '0;
            en_q          <= '0;
            stall_cnt     <= '0;
            event_count_o <= '0;
            timeout_err_o <= 1'b0;
        end else begin
            state         <= state_nx;
            sel           <= sel_nx;
            en_q          <= en_q_nx;
            stall_cnt     <= stall_nx;
            event_count_o <= event_cnt_nx;
            timeout_err_o <= err_nx;
        end
    end

    assign cur_surf_o = sel;

endmodule
